hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 4, EX-stage occupancy in cycles of a multi-cycle mul/div op (legal 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have ports Rs1D, Rs2D  input  5 each  decode-stage source registers.
REQ-005 SHALL have ports Rs1E, Rs2E, RdE  input  5 each  execute-stage source/destination registers.
REQ-006 SHALL have ports RdM, RdW  input  5 each  memory/writeback destination registers.
REQ-007 SHALL have ports RegWriteM, RegWriteW  input  1 each  register writes pending in M and W.
REQ-008 SHALL have port ResultSrcE  input  2  EX result select; 2'b01 marks a load.
REQ-009 SHALL have port PCSrcE  input  1  taken branch or jump resolved in EX.
REQ-010 SHALL have port MdStartE  input  1  EX holds a multi-cycle mul/div instruction.
REQ-011 SHALL have ports ForwardAE, ForwardBE  output  2 each  EX operand bypass select.
REQ-012 SHALL have ports StallF, StallD, StallE  output  1 each  hold PC, IF/ID and ID/EX registers.
REQ-013 SHALL have ports FlushD, FlushE, FlushM  output  1 each  clear IF/ID, ID/EX and EX/MEM registers.
REQ-014 SHALL have ports MdBusy, MdDoneE  output  1 each  mul/div in progress; final EX cycle of the op.

Function
REQ-015 ForwardAE SHALL be 2'b10 if RegWriteM, RdM!=0 and RdM==Rs1E; else 2'b01 if RegWriteW, RdW!=0 and RdW==Rs1E; else 2'b00. ForwardBE is identical using Rs2E.
REQ-016 Forwarding SHALL be combinational, with M taking priority over W.
REQ-017 lwStall SHALL be ResultSrcE==2'b01 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D), evaluated combinationally.
REQ-018 The mul/div FSM SHALL have two states: IDLE and BUSY, plus a counter cnt of $clog2(MD_LATENCY) bits.
REQ-019 In IDLE with MdStartE=1 and PCSrcE=0, the FSM SHALL go to BUSY with cnt<=1 at the next edge.
REQ-020 In BUSY, cnt SHALL increment each cycle. When cnt==MD_LATENCY-1 the FSM SHALL return to IDLE and cnt<=0.
REQ-021 In BUSY, MdStartE SHALL be ignored, because the same instruction is held.
REQ-022 mdHold SHALL be (IDLE and MdStartE and !PCSrcE) or (BUSY and cnt!=MD_LATENCY-1).
REQ-023 MdDoneE SHALL be (BUSY and cnt==MD_LATENCY-1), so the op occupies EX exactly MD_LATENCY cycles.
REQ-024 MdBusy SHALL equal the state being BUSY (registered).
REQ-025 StallF and StallD SHALL equal lwStall or mdHold; StallE SHALL equal mdHold.
REQ-026 FlushM SHALL equal mdHold, inserting a bubble downstream while EX is held.
REQ-027 FlushD SHALL equal PCSrcE.
REQ-028 FlushE SHALL equal PCSrcE or (lwStall and !mdHold).
REQ-029 When a stall and a flush target the same register (a simultaneous event), the flush SHALL win and the stall is don't-care for that register.
REQ-030 In IDLE, MdStartE together with PCSrcE SHALL be treated as a killed op: no transition, and mdHold=0.

Reset
REQ-031 On reset=0 the state SHALL asynchronously become IDLE, with cnt=0 and MdBusy=0.
REQ-032 On reset=0 MdDoneE SHALL be 0; all stall and flush outputs then follow only their combinational inputs.
REQ-033 Reset asserted mid-operation SHALL abandon the op immediately, with no MdDoneE pulse.
REQ-034 The first MdStartE after reset release SHALL start a fresh full MD_LATENCY count.

Structure
REQ-035 A shared package hazard_pkg SHALL hold: the forward-select constants FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; RES_LOAD=2'b01; and the md_state_t enum {IDLE, BUSY}.
REQ-036 The FSM and counter SHALL live in sub-module md_stall_fsm (ports clk, reset, MdStartE, PCSrcE, mdHold, MdBusy, MdDoneE).
REQ-037 Forwarding and load-use logic SHALL stay combinational in the top level.

Verification
REQ-038 Scenario: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=2'b10; then RdM=0 -> ForwardAE=2'b01; then RdW=0 -> 2'b00.
REQ-039 Scenario: ResultSrcE=2'b01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 and StallE=0; with RdE=0 -> all 0.
REQ-040 Scenario: MD_LATENCY=4, MdStartE held high -> StallE=1 for 3 cycles, MdDoneE=1 on the 4th cycle, then IDLE.
REQ-041 Scenario: MdStartE=1 and PCSrcE=1 in IDLE -> FlushD=FlushE=1, MdBusy stays 0, StallE=0.
REQ-042 Scenario: reset=0 at cnt=2 -> MdBusy=0 immediately, no MdDoneE; after release, MdStartE -> a full 4-cycle occupancy.
REQ-043 Scenario: load-use condition during BUSY -> StallF=StallD=1, FlushE=0, FlushM=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   FWD_*      : EX operand bypass select encodings
//   RES_LOAD   : ResultSrcE encoding that marks a load in EX
//   md_state_t : multi-cycle mul/div occupancy FSM states
//   fwd_sel    : bypass select for one EX source operand
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // M has priority over W because it carries the younger result; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_MEM;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/md_stall_fsm.sv
// Multi-cycle mul/div occupancy tracker: holds EX for MD_LATENCY cycles.
// Ports:
//   clk, reset (async, active-low)
//   MdStartE : EX holds a mul/div instruction
//   PCSrcE   : taken branch/jump in EX (kills a not-yet-started op)
//   mdHold   : EX must be held this cycle (combinational)
//   MdBusy   : FSM is in BUSY (decoded from the state register)
//   MdDoneE  : final EX cycle of the op (combinational)
module md_stall_fsm
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic MdStartE,
    input  logic PCSrcE,
    output logic mdHold,
    output logic MdBusy,
    output logic MdDoneE
);

    localparam int unsigned CNT_W = $clog2(MD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_LATENCY - 1);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, counter and hold/done decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mdHold    = 1'b0;
        MdDoneE   = 1'b0;
        unique case (state)
            IDLE: begin
                // A start that coincides with a redirect is a killed op.
                if (MdStartE && !PCSrcE) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_W'(1);
                    mdHold    = 1'b1;
                end
            end
            BUSY: begin
                // MdStartE is ignored here: it is the same held instruction.
                if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    MdDoneE   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    mdHold  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign MdBusy = (state == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX bypass selects, load-use stall,
// branch flush and multi-cycle mul/div hold of the EX stage.
// Ports:
//   clk, reset (async, active-low)
//   Rs1D/Rs2D, Rs1E/Rs2E/RdE, RdM/RdW : pipeline register specifiers
//   RegWriteM/RegWriteW               : pending writes in M and W
//   ResultSrcE, PCSrcE, MdStartE      : EX-stage control
//   ForwardAE/ForwardBE               : EX operand bypass selects
//   StallF/StallD/StallE, FlushD/FlushE/FlushM : pipeline register control
//   MdBusy, MdDoneE                   : mul/div status
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic       MdStartE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       MdBusy,
    output logic       MdDoneE
);

    logic lw_stall;
    logic md_hold;

    // Operand bypass.
    assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    // Load in EX feeding an instruction in D.
    assign lw_stall = (ResultSrcE == RES_LOAD) && (RdE != 5'd0)
                      && ((RdE == Rs1D) || (RdE == Rs2D));

    md_stall_fsm #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_fsm (
        .clk      (clk),
        .reset    (reset),
        .MdStartE (MdStartE),
        .PCSrcE   (PCSrcE),
        .mdHold   (md_hold),
        .MdBusy   (MdBusy),
        .MdDoneE  (MdDoneE)
    );

    // While EX is held the load bubble must not overwrite the held op,
    // so FlushE only fires for the load-use case when EX is free.
    assign StallF = lw_stall | md_hold;
    assign StallD = lw_stall | md_hold;
    assign StallE = md_hold;
    assign FlushD = PCSrcE;
    assign FlushE = PCSrcE | (lw_stall & ~md_hold);
    assign FlushM = md_hold;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MD_LATENCY = 4).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MdStartE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic       MdBusy, MdDoneE;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LATENCY(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .MdStartE   (MdStartE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushM     (FlushM),
        .MdBusy     (MdBusy),
        .MdDoneE    (MdDoneE)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Step to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0; MdStartE = 1'b0;
    endtask

    initial begin
        int occ;
        bit done;

        reset = 1'b0;
        clear_inputs();
        #12;
        check("rst_busy",  int'(MdBusy),  0);
        check("rst_done",  int'(MdDoneE), 0);
        check("rst_stalle", int'(StallE), 0);
        check("rst_fwda",  int'(ForwardAE), 0);
        tick();
        reset = 1'b1;

        // Forwarding priority M over W, then W alone, then none.
        RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd9;
        #1;
        check("fwda_mem", int'(ForwardAE), 2);
        check("fwdb_none", int'(ForwardBE), 0);
        RdM = 5'd0; #1;
        check("fwda_wb", int'(ForwardAE), 1);
        RdW = 5'd0; #1;
        check("fwda_none", int'(ForwardAE), 0);
        RdM = 5'd9; #1;
        check("fwdb_mem", int'(ForwardBE), 2);
        RegWriteM = 1'b0; RdW = 5'd9; #1;
        check("fwdb_wb_nowem", int'(ForwardBE), 1);
        Rs1E = 5'd0; RdW = 5'd0; RegWriteW = 1'b1; #1;
        check("fwda_x0", int'(ForwardAE), 0);
        clear_inputs();

        // Load-use stall.
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; #1;
        check("lu_stallf", int'(StallF), 1);
        check("lu_stalld", int'(StallD), 1);
        check("lu_flushe", int'(FlushE), 1);
        check("lu_stalle", int'(StallE), 0);
        check("lu_flushm", int'(FlushM), 0);
        RdE = 5'd0; Rs2D = 5'd0; #1;
        check("lu_x0_stallf", int'(StallF), 0);
        check("lu_x0_flushe", int'(FlushE), 0);
        RdE = 5'd7; Rs1D = 5'd7; ResultSrcE = 2'b00; #1;
        check("lu_notload", int'(StallD), 0);
        ResultSrcE = 2'b01; PCSrcE = 1'b1; #1;
        check("lu_br_flushd", int'(FlushD), 1);
        check("lu_br_flushe", int'(FlushE), 1);
        clear_inputs();

        // Mul/div occupancy: 3 held cycles then the done cycle.
        tick();
        MdStartE = 1'b1; #1;
        check("md_c0_stalle", int'(StallE), 1);
        check("md_c0_flushm", int'(FlushM), 1);
        check("md_c0_busy", int'(MdBusy), 0);
        check("md_c0_done", int'(MdDoneE), 0);
        for (int i = 1; i <= 2; i++) begin
            tick();
            check($sformatf("md_c%0d_stalle", i), int'(StallE), 1);
            check($sformatf("md_c%0d_busy", i), int'(MdBusy), 1);
            check($sformatf("md_c%0d_done", i), int'(MdDoneE), 0);
        end
        tick();
        check("md_c3_stalle", int'(StallE), 0);
        check("md_c3_done", int'(MdDoneE), 1);
        check("md_c3_busy", int'(MdBusy), 1);
        MdStartE = 1'b0;
        tick();
        check("md_end_busy", int'(MdBusy), 0);
        check("md_end_done", int'(MdDoneE), 0);

        // Killed op: start with a redirect in IDLE.
        MdStartE = 1'b1; PCSrcE = 1'b1; #1;
        check("kill_flushd", int'(FlushD), 1);
        check("kill_flushe", int'(FlushE), 1);
        check("kill_stalle", int'(StallE), 0);
        tick();
        check("kill_busy", int'(MdBusy), 0);
        clear_inputs();

        // Reset mid-operation at cnt=2.
        tick();
        MdStartE = 1'b1;
        tick();
        tick();
        check("mid_busy_pre", int'(MdBusy), 1);
        reset = 1'b0; MdStartE = 1'b0; #1;
        check("mid_rst_busy", int'(MdBusy), 0);
        check("mid_rst_done", int'(MdDoneE), 0);
        tick();
        check("mid_rst_done2", int'(MdDoneE), 0);
        reset = 1'b1;
        tick();
        MdStartE = 1'b1; #1;
        occ = 1;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            tick();
            occ++;
            if (MdDoneE) done = 1'b1;
        end
        check("post_rst_done_seen", int'(done), 1);
        check("post_rst_occupancy", occ, 4);
        MdStartE = 1'b0;
        tick();
        check("post_rst_idle", int'(MdBusy), 0);

        // Load-use arriving while mul/div holds EX.
        MdStartE = 1'b1;
        tick();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7; #1;
        check("busy_lu_stallf", int'(StallF), 1);
        check("busy_lu_stalld", int'(StallD), 1);
        check("busy_lu_flushe", int'(FlushE), 0);
        check("busy_lu_flushm", int'(FlushM), 1);
        check("busy_lu_stalle", int'(StallE), 1);
        tick();
        tick();
        clear_inputs();
        tick();
        check("busy_lu_idle", int'(MdBusy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
